// File: rtl/pio_pkg.sv
// pio_pkg
// Shared definitions for the program loader slice: the loader state
// encoding, the instruction word width and the default address width.
// No ports; imported by prog_loader and byte_pair_assembler.
package pio_pkg;

  localparam int INSTR_W        = 16;
  localparam int DEFAULT_ADDR_W = 5;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_ADDR,
    LD_COUNT,
    LD_HI,
    LD_LO,
    LD_CHK,
    LD_DONE
  } ld_state_t;

endpackage

// File: rtl/byte_pair_assembler.sv
// byte_pair_assembler
// Builds 16-bit instructions out of a high/low byte pair. The high byte is
// held until the low byte arrives, then the full word is presented for
// exactly one cycle alongside word_valid.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   in_data     stream byte
//   hi_stb      in_data is the high byte of a word (accepted this edge)
//   lo_stb      in_data is the low byte of a word (accepted this edge)
//   word_valid  one-cycle strobe, the cycle after lo_stb
//   word        {hi, lo}, holds its value between strobes
module byte_pair_assembler
  import pio_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               hi_stb,
  input  logic               lo_stb,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word
);

  logic [7:0] hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q       <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= lo_stb;
      if (hi_stb) hi_q <= in_data;
      if (lo_stb) word <= {hi_q, in_data};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader
// Byte-stream program loader feeding the instruction regfile write port.
// Frame: ADDR, COUNT (words = COUNT+1), COUNT+1 pairs of HI/LO bytes, and a
// trailing CHK byte when LOADER_CHECKSUM_EN is defined (running XOR of every
// byte from ADDR through the last LO). On completion the loaded window is
// published on wrap_bottom/wrap_top for the program counter.
// Optional feature macro: LOADER_CHECKSUM_EN.
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   in_data/in_valid/in_ready  byte stream handshake
//   write_addr/write_data/write_en  regfile write port, one strobe per word
//   wrap_bottom/wrap_top    first/last address of the last loaded program
//   loading                 a frame is in progress
//   done                    one-cycle pulse when a frame completes
//   error                   one-cycle checksum failure pulse (0 without macro)
module prog_loader
  import pio_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int WRAP_TOP_RST = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [ADDR_W-1:0]  write_addr,
  output logic [INSTR_W-1:0] write_data,
  output logic               write_en,
  output logic [ADDR_W-1:0]  wrap_bottom,
  output logic [ADDR_W-1:0]  wrap_top,
  output logic               loading,
  output logic               done,
  output logic               error
);

  ld_state_t state, next_state;

  logic              accept;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] count_m1;
  logic [ADDR_W-1:0] words_left;
  logic              last_word;

  assign accept    = in_valid && in_ready;
  assign last_word = (words_left == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LD_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    unique case (state)
      LD_IDLE:  next_state = LD_ADDR;
      LD_ADDR: begin
        in_ready = 1'b1;
        if (accept) next_state = LD_COUNT;
      end
      LD_COUNT: begin
        in_ready = 1'b1;
        if (accept) next_state = LD_HI;
      end
      LD_HI: begin
        in_ready = 1'b1;
        if (accept) next_state = LD_LO;
      end
      LD_LO: begin
        in_ready = 1'b1;
        if (accept) begin
          if (!last_word) next_state = LD_HI;
`ifdef LOADER_CHECKSUM_EN
          else            next_state = LD_CHK;
`else
          else            next_state = LD_DONE;
`endif
        end
      end
      LD_CHK: begin
        in_ready = 1'b1;
        if (accept) next_state = LD_DONE;
      end
      LD_DONE:  next_state = LD_IDLE;
      default:  next_state = LD_IDLE;
    endcase
  end

  byte_pair_assembler u_pair (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .hi_stb     (accept && (state == LD_HI)),
    .lo_stb     (accept && (state == LD_LO)),
    .word_valid (write_en),
    .word       (write_data)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] run_xor;
  logic       chk_ok;
`endif

  // Address counter, word countdown and window registers. The wrap window
  // is loaded on the edge that enters DONE, so it is already valid while
  // done is high. Address arithmetic wraps naturally at ADDR_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr    <= '0;
      start_addr  <= '0;
      count_m1    <= '0;
      words_left  <= '0;
      write_addr  <= '0;
      wrap_bottom <= '0;
      wrap_top    <= ADDR_W'(WRAP_TOP_RST);
`ifdef LOADER_CHECKSUM_EN
      run_xor     <= '0;
      chk_ok      <= 1'b0;
`endif
    end else if (accept) begin
      unique case (state)
        LD_ADDR: begin
          cur_addr   <= in_data[ADDR_W-1:0];
          start_addr <= in_data[ADDR_W-1:0];
`ifdef LOADER_CHECKSUM_EN
          run_xor    <= in_data;
`endif
        end
        LD_COUNT: begin
          count_m1   <= in_data[ADDR_W-1:0];
          words_left <= in_data[ADDR_W-1:0];
`ifdef LOADER_CHECKSUM_EN
          run_xor    <= run_xor ^ in_data;
`endif
        end
        LD_HI: begin
`ifdef LOADER_CHECKSUM_EN
          run_xor    <= run_xor ^ in_data;
`endif
        end
        LD_LO: begin
          write_addr <= cur_addr;
          cur_addr   <= cur_addr + 1'b1;
          words_left <= words_left - 1'b1;
`ifdef LOADER_CHECKSUM_EN
          run_xor    <= run_xor ^ in_data;
`else
          if (last_word) begin
            wrap_bottom <= start_addr;
            wrap_top    <= start_addr + count_m1;
          end
`endif
        end
        LD_CHK: begin
`ifdef LOADER_CHECKSUM_EN
          // A bad checksum leaves the previous window in place; words
          // already written are not rolled back.
          chk_ok <= (in_data == run_xor);
          if (in_data == run_xor) begin
            wrap_bottom <= start_addr;
            wrap_top    <= start_addr + count_m1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign loading = (state != LD_IDLE) && (state != LD_DONE);

`ifdef LOADER_CHECKSUM_EN
  assign done  = (state == LD_DONE) && chk_ok;
  assign error = (state == LD_DONE) && !chk_ok;
`else
  assign done  = (state == LD_DONE);
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Self-checking bench for prog_loader. Frames are described as byte lists;
// a frame-level model derives the expected regfile writes and window from
// the frame contents, and a negedge process compares the DUT every cycle.
// Honours LOADER_CHECKSUM_EN (CHK byte appended automatically).
module tb_prog_loader;

  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] write_addr;
  logic [15:0]   write_data;
  logic          write_en;
  logic [AW-1:0] wrap_bottom;
  logic [AW-1:0] wrap_top;
  logic          loading;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(AW), .WRAP_TOP_RST(31)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .write_en    (write_en),
    .wrap_bottom (wrap_bottom),
    .wrap_top    (wrap_top),
    .loading     (loading),
    .done        (done),
    .error       (error)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t           expQ[$];
  logic [7:0]    txBytes[$];
  int            testsRun    = 0;
  int            testsFailed = 0;
  logic [AW-1:0] modelBottom;
  logic [AW-1:0] modelTop;
  logic          expDone;
  logic          expError;
  logic          checkEn;
  logic [AW-1:0] lastWrAddr;
  logic [15:0]   lastWrData;
  int            wrCount;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Every-cycle comparison against the frame model.
  always @(negedge clk) begin : compare
    wr_t e;
    if (checkEn && !rst) begin
      if (write_en) begin
        wrCount++;
        lastWrAddr = write_addr;
        lastWrData = write_data;
        if (expQ.size() == 0) begin
          checkOutput("unexpected write_en", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("write_addr", 32'(write_addr), 32'(e.addr));
          checkOutput("write_data", 32'(write_data), 32'(e.data));
        end
      end else if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("missing write_en", 32'd0, 32'd1);
      end
      checkOutput("done", 32'(done), 32'(expDone));
      checkOutput("error", 32'(error), 32'(expError));
      checkOutput("wrap_bottom", 32'(wrap_bottom), 32'(modelBottom));
      checkOutput("wrap_top", 32'(wrap_top), 32'(modelTop));
      if (expDone) checkOutput("loading in DONE", 32'(loading), 32'd0);
    end
  end

  // Sends txBytes (plus a CHK byte when checksums are enabled, offset by
  // chkDelta to corrupt it). stopAfter >= 0 truncates the frame.
  task automatic applyStimulus(input bit toggleValid, input int stopAfter,
                               input logic [7:0] chkDelta);
    logic [7:0] bytes[$];
    logic [7:0] hi;
    logic [7:0] xr;
    int         start;
    int         count;
    int         nBytes;
    int         waitCycles;
    bit         ok;
    wr_t        w;
    bytes = txBytes;
    start = int'(bytes[0]) % DEPTH;
    count = (int'(bytes[1]) % DEPTH) + 1;
    xr    = 8'h00;
    hi    = 8'h00;
    foreach (bytes[i]) xr = xr ^ bytes[i];
`ifdef LOADER_CHECKSUM_EN
    bytes.push_back(xr ^ chkDelta);
`endif
    nBytes = (stopAfter >= 0) ? stopAfter : bytes.size();
    for (int k = 0; k < nBytes; k++) begin
      if (toggleValid) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid   = 1'b1;
      in_data    = bytes[k];
      waitCycles = 0;
      @(negedge clk);
      while (!in_ready && waitCycles < 20) begin
        waitCycles++;
        @(negedge clk);
      end
      if (!in_ready) begin
        checkOutput("in_ready timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      checkOutput("loading while accepting", 32'(loading), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (k >= 2 && k < 2 + 2 * count) begin
        if ((k - 2) % 2 == 0) begin
          hi = bytes[k];
        end else begin
          w.addr = AW'((start + (k - 2) / 2) % DEPTH);
          w.data = {hi, bytes[k]};
          expQ.push_back(w);
        end
      end
      if (k == bytes.size() - 1) begin
        ok = (bytes.size() == 2 + 2 * count) || (bytes[k] == xr);
        if (ok) begin
          modelBottom = AW'(start);
          modelTop    = AW'((start + count - 1) % DEPTH);
          expDone     = 1'b1;
        end else begin
          expError    = 1'b1;
        end
        @(posedge clk);
        #1;
        expDone  = 1'b0;
        expError = 1'b0;
      end
    end
  endtask

  task automatic doReset();
    rst         = 1'b1;
    in_valid    = 1'b0;
    expQ.delete();
    modelBottom = '0;
    modelTop    = AW'(31);
    expDone     = 1'b0;
    expError    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int base;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; checkEn = 1'b0;
    modelBottom = '0; modelTop = AW'(31); expDone = 1'b0; expError = 1'b0;
    wrCount = 0; lastWrAddr = '0; lastWrData = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset write_en", 32'(write_en), 32'd0);
    checkOutput("reset write_addr", 32'(write_addr), 32'd0);
    checkOutput("reset write_data", 32'(write_data), 32'd0);
    checkOutput("reset wrap_bottom", 32'(wrap_bottom), 32'd0);
    checkOutput("reset wrap_top", 32'(wrap_top), 32'd31);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset error", 32'(error), 32'd0);
    checkOutput("reset loading", 32'(loading), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkEn = 1'b1;

    // Single word at address 0.
    base = wrCount;
    txBytes = '{8'h00, 8'h00, 8'hA0, 8'h01};
    applyStimulus(1'b0, -1, 8'h00);
    checkOutput("f1 write count", 32'(wrCount - base), 32'd1);
    checkOutput("f1 last addr", 32'(lastWrAddr), 32'h00);
    checkOutput("f1 last data", 32'(lastWrData), 32'hA001);
    checkOutput("f1 wrap_bottom", 32'(wrap_bottom), 32'h00);
    checkOutput("f1 wrap_top", 32'(wrap_top), 32'h00);

    // Three words wrapping past the top of memory.
    base = wrCount;
    txBytes = '{8'h1E, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
    applyStimulus(1'b0, -1, 8'h00);
    checkOutput("f2 write count", 32'(wrCount - base), 32'd3);
    checkOutput("f2 last addr", 32'(lastWrAddr), 32'h00);
    checkOutput("f2 last data", 32'(lastWrData), 32'h3333);
    checkOutput("f2 wrap_bottom", 32'(wrap_bottom), 32'h1E);
    checkOutput("f2 wrap_top", 32'(wrap_top), 32'h00);

    // Same frame with in_valid gaps.
    base = wrCount;
    applyStimulus(1'b1, -1, 8'h00);
    checkOutput("f3 write count", 32'(wrCount - base), 32'd3);
    checkOutput("f3 wrap_top", 32'(wrap_top), 32'h00);

    // Reset after the HI byte of word 2.
    base = wrCount;
    txBytes = '{8'h03, 8'h02, 8'hAA, 8'h01, 8'hBB, 8'h02, 8'hCC, 8'h03};
    applyStimulus(1'b0, 5, 8'h00);
    doReset();
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort write count", 32'(wrCount - base), 32'd1);
    checkOutput("abort wrap_bottom", 32'(wrap_bottom), 32'h00);
    checkOutput("abort wrap_top", 32'(wrap_top), 32'd31);
    txBytes = '{8'h04, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    applyStimulus(1'b0, -1, 8'h00);
    checkOutput("post-abort last data", 32'(lastWrData), 32'hBEEF);
    checkOutput("post-abort wrap_top", 32'(wrap_top), 32'h05);

    // Full-depth load starting at 5 (COUNT upper bits ignored).
    base = wrCount;
    txBytes.delete();
    txBytes.push_back(8'h05);
    txBytes.push_back(8'hFF);
    for (int i = 0; i < DEPTH; i++) begin
      txBytes.push_back(8'hC0);
      txBytes.push_back(8'(i));
    end
    applyStimulus(1'b0, -1, 8'h00);
    checkOutput("full write count", 32'(wrCount - base), 32'd32);
    checkOutput("full last addr", 32'(lastWrAddr), 32'h04);
    checkOutput("full last data", 32'(lastWrData), 32'hC01F);
    checkOutput("full wrap_bottom", 32'(wrap_bottom), 32'h05);
    checkOutput("full wrap_top", 32'(wrap_top), 32'h04);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum (27 instead of 26): word written, window unchanged.
    txBytes = '{8'h00, 8'h00, 8'h12, 8'h34};
    applyStimulus(1'b0, -1, 8'h01);
    checkOutput("badchk last addr", 32'(lastWrAddr), 32'h00);
    checkOutput("badchk last data", 32'(lastWrData), 32'h1234);
    checkOutput("badchk wrap_bottom", 32'(wrap_bottom), 32'h05);
    checkOutput("badchk wrap_top", 32'(wrap_top), 32'h04);
    // Good checksum 26.
    applyStimulus(1'b0, -1, 8'h00);
    checkOutput("goodchk wrap_bottom", 32'(wrap_bottom), 32'h00);
    checkOutput("goodchk wrap_top", 32'(wrap_top), 32'h00);
`endif

    repeat (4) @(posedge clk);
    #1;
    checkEn = 1'b0;
    checkOutput("leftover expected writes", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
